// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit.
// A Moore FSM steps each instruction class through the shared datapath.
// It drives the mux selects, the write enables and the immediate-extender select.
// irwrite, pcwrite and instr_retired also depend on mem_ready or zero.
// An illegal opcode, or a branch with a funct3 other than beq, parks the FSM in ILLEGAL.
// Only reset leaves ILLEGAL.
module mc_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [1:0]         immsrc,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         aluop,
    output logic [2:0]         alucontrol,
    output logic [1:0]         resultsrc,
    output logic               adrsrc,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               regwrite,
    output logic               memwrite,
    output logic               illegal_instr,
    output logic               instr_retired,
    output logic [STATE_W-1:0] dbg_state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECUTER = STATE_W'(6),
        EXECUTEI = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9),
        JAL      = STATE_W'(10),
        ILLEGAL  = STATE_W'(11)
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state;

    assign dbg_state = state;

    // State register: reset wins over every transition, including ILLEGAL and memory stalls.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECUTER;
                        OP_I:         state <= EXECUTEI;
                        OP_BR:        state <= BRANCH;
                        OP_JAL:       state <= JAL;
                        default:      state <= ILLEGAL;
                    endcase
                end
                MEMADR:   state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (mem_ready) state <= FETCH;
                EXECUTER: state <= ALUWB;
                EXECUTEI: state <= ALUWB;
                ALUWB:    state <= FETCH;
                BRANCH:   state <= (funct3 == 3'b000) ? FETCH : ILLEGAL;
                JAL:      state <= ALUWB;
                ILLEGAL:  state <= ILLEGAL;
                default:  state <= FETCH;
            endcase
        end
    end

    // Moore decode of selects and enables from the current state, plus the mem_ready/zero gates.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alusrca       = 2'b00;
        alusrcb       = 2'b00;
        aluop         = 2'b00;
        resultsrc     = 2'b00;
        adrsrc        = 1'b0;
        irwrite       = 1'b0;
        pcwrite       = 1'b0;
        regwrite      = 1'b0;
        memwrite      = 1'b0;
        illegal_instr = 1'b0;
        instr_retired = 1'b0;
        case (state)
            FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = mem_ready;
                pcwrite   = mem_ready;
            end
            DECODE: begin
                // Precompute the branch target as oldPC + imm.
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            MEMREAD: begin
                adrsrc = 1'b1;
            end
            MEMWB: begin
                resultsrc     = 2'b01;
                regwrite      = 1'b1;
                instr_retired = 1'b1;
            end
            MEMWRITE: begin
                adrsrc        = 1'b1;
                memwrite      = 1'b1;
                instr_retired = mem_ready;
            end
            EXECUTER: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
            end
            EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regwrite      = 1'b1;
                instr_retired = 1'b1;
            end
            BRANCH: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                // Only beq is supported; other funct3 values fall into ILLEGAL without side effects.
                if (funct3 == 3'b000) begin
                    pcwrite       = zero;
                    instr_retired = 1'b1;
                end
            end
            JAL: begin
                alusrca = 2'b01;
                alusrcb = 2'b10;
                pcwrite = 1'b1;
            end
            ILLEGAL: begin
                illegal_instr = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate format follows the opcode, independent of state.
    always_comb begin
        case (op)
            OP_LW, OP_I: immsrc = 2'b00;
            OP_SW:       immsrc = 2'b01;
            OP_BR:       immsrc = 2'b10;
            OP_JAL:      immsrc = 2'b11;
            default:     immsrc = 2'b00;
        endcase
    end

    // ALU operation: add or compare by aluop, otherwise decoded from funct3/funct7.
    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    // funct7b5 selects sub only for R-type; for I-type it is immediate bits.
                    3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

endmodule
